// File: rtl/sync_bus_pkg.sv
// Shared definitions for the synchronous bus read master.
// Holds the FSM state encoding, bus widths, the error data pattern and
// the default idle bus address.
package sync_bus_pkg;

    localparam int          BUS_AW         = 8;
    localparam int          BUS_DW         = 8;
    localparam logic [7:0]  ERR_DATA       = 8'hFF;
    localparam logic [7:0]  IDLE_ADDR_DFLT = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_bus_master_counter.sv
// bus_wait_counter: loadable up-counter with synchronous clear, enable and
// a terminal-count compare against a run-time terminal value.
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   clr_i          clear to zero (highest priority)
//   ld_i, ld_val_i load a value (second priority)
//   en_i           increment by one
//   term_i         terminal value
//   tc_o           high while the count equals term_i
module bus_wait_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         en_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear beats load beats increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {W{1'b0}};
        end else if (ld_i) begin
            cnt_d = ld_val_i;
        end else if (en_i) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == term_i);

endmodule

// File: rtl/sync_bus_master.sv
// sync_bus_master: synchronous read master for the shared 8-bit bus.
// Accepts a read request, drives bus_addr/bus_rd for SETUP_CYCLES before
// sampling bus_ack, then returns the captured byte (or ERR_DATA with
// rsp_err=1 after TIMEOUT ack-less samples) on the response interface.
// Ports:
//   clock, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready/req_addr request handshake and read address
//   rsp_valid/rsp_ready          response handshake
//   rsp_data/rsp_err             read byte and timeout flag
//   bus_addr/bus_rd              bus address and read strobe (registered)
//   bus_data/bus_ack             device data and acknowledge
module sync_bus_master
    import sync_bus_pkg::*;
#(
    parameter int         SETUP_CYCLES = 1,
    parameter int         TIMEOUT      = 8,
    parameter logic [7:0] IDLE_ADDR    = IDLE_ADDR_DFLT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [BUS_AW-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [BUS_DW-1:0] rsp_data,
    output logic              rsp_err,
    output logic [BUS_AW-1:0] bus_addr,
    output logic              bus_rd,
    input  logic [BUS_DW-1:0] bus_data,
    input  logic              bus_ack
);

    // Terminal values: SETUP ends on its last cycle, WAIT fails on the
    // TIMEOUT-th ack-less sample.
    localparam logic [7:0] SETUP_TERM   = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_TERM = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [BUS_AW-1:0] bus_addr_q, bus_addr_d;
    logic              bus_rd_q, bus_rd_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [BUS_DW-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic              cnt_clr_s;
    logic              cnt_en_s;
    logic [7:0]        cnt_term_s;
    logic              cnt_tc_s;

    // One counter serves both phases; the terminal value follows the state.
    bus_wait_counter #(
        .W (8)
    ) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .clr_i    (cnt_clr_s),
        .ld_i     (1'b0),
        .ld_val_i (8'h00),
        .en_i     (cnt_en_s),
        .term_i   (cnt_term_s),
        .tc_o     (cnt_tc_s)
    );

    // Next-state, next-output and counter control.
    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_rd_d    = bus_rd_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        cnt_clr_s   = 1'b0;
        cnt_en_s    = 1'b0;
        cnt_term_s  = TIMEOUT_TERM;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    bus_addr_d = req_addr;
                    bus_rd_d   = 1'b1;
                    cnt_clr_s  = 1'b1;
                    state_d    = SETUP;
                end else begin
                    state_d    = IDLE;
                end
            end
            SETUP: begin
                cnt_term_s = SETUP_TERM;
                if (cnt_tc_s) begin
                    cnt_clr_s = 1'b1;
                    state_d   = WAIT;
                end else begin
                    cnt_en_s  = 1'b1;
                end
            end
            WAIT: begin
                cnt_term_s = TIMEOUT_TERM;
                // Ack is checked first so it wins over a coincident timeout.
                if (bus_ack) begin
                    rsp_data_d  = bus_data;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    bus_rd_d    = 1'b0;
                    bus_addr_d  = IDLE_ADDR;
                    state_d     = RESP;
                end else if (cnt_tc_s) begin
                    rsp_data_d  = ERR_DATA;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    bus_rd_d    = 1'b0;
                    bus_addr_d  = IDLE_ADDR;
                    state_d     = RESP;
                end else begin
                    cnt_en_s    = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d     = RESP;
                end
            end
            default: begin
                state_d     = IDLE;
                bus_rd_d    = 1'b0;
                bus_addr_d  = IDLE_ADDR;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered bus/response outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bus_addr_q  <= IDLE_ADDR;
            bus_rd_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_rd_q    <= bus_rd_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign bus_addr  = bus_addr_q;
    assign bus_rd    = bus_rd_q;

endmodule
